insn_prefetch_queue: RTL and testbench
======================================

// Module: insn_prefetch_queue
// PURPOSE
//  Parametrised instruction fetch unit for the multi-cycle CPU core. It replaces the core's single-word
//  fetch/fetch-wait states with a decoupled prefetcher. It issues sequential word fetches on the data bus
//  (one outstanding at a time) and buffers up to DEPTH instructions with their PC and MMU exception code.
//  The decode stage pops entries through a valid/ready handshake; branches, exceptions and eret redirect it.
// PARAMETERS
//  DEPTH     4             queue entries; power of two, >= 2
//  RESET_PC  32'h80000000  fetch PC loaded by reset
//  EXC_W     3             width of MMU exception code; 0 = none
//  EXC_ALIGN 3'd7          code enqueued for a misaligned redirect PC (must be != 0)
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  res          in   1      reset
//  enable       in   1      allow new fetches to issue (CPU ready)
//  bus_req      out  1      fetch request to memory bus
//  bus_addr     out  32     fetch address, stable while bus_req=1
//  bus_dataIn   in   32     fetched word, valid when bus_ready=1
//  bus_ready    in   1      request completed successfully
//  bus_exc      in   EXC_W  MMU exception for current request; nonzero also completes it
//  redirect     in   1      flush queue and restart fetch at redirect_pc
//  redirect_pc  in   32     new fetch PC
//  deq_valid    out  1      head entry valid
//  deq_ready    in   1      consumer pops head when deq_valid=1
//  deq_ins      out  32     head instruction word
//  deq_pc       out  32     head instruction PC
//  deq_exc      out  EXC_W  head exception code (0 = none)
//  count        out  $clog2(DEPTH)+1  entries currently held
// BEHAVIOUR
//  - Reset is synchronous, active-high. It takes effect even mid-request; the bus must tolerate bus_req dropping.
//  - Reset values: bus_req=0, bus_addr=RESET_PC, deq_valid=0, count=0, halted=0, drop=0.
//    All storage is reset to 0, so deq_ins=0, deq_pc=0, deq_exc=0.
//  - State: fetch_pc, head/tail pointers (log2 DEPTH, wrap modulo DEPTH), count,
//    busy (request outstanding), drop (discard the pending response), halted (stop after an exception).
//  - Issue: at an edge where enable=1, !halted, !redirect, and (count + busy - pops + (completes && !drop)) < DEPTH:
//    - if no request is outstanding or one completes this edge, set bus_req=1 and bus_addr=fetch_pc;
//    - then fetch_pc += 4, mod 2^32.
//    - Back-to-back: a completion and a new issue on the same edge keep bus_req high with the new address.
//  - Completion is bus_ready=1 or bus_exc!=0 while bus_req=1.
//    - If bus_ready and bus_exc are both set, the exception wins: the entry gets bus_exc and the word is stored anyway.
//    - If drop=0, enqueue {bus_dataIn, bus_addr, bus_exc} at the tail.
//    - If bus_exc!=0, set halted. No further fetches issue until the next redirect.
//    - If drop=1, discard the response and clear drop.
//    - If no new issue happens on the edge, bus_req goes to 0.
//  - Latency: completion edge -> deq_valid=1 on the next cycle. deq_* are combinational views of the head entry.
//  - Pop: deq_valid && deq_ready && !redirect advances head.
//    Simultaneous pop and enqueue leave count unchanged. Pop at count=1 with enqueue keeps deq_valid=1.
//  - Overflow is impossible: issue reserves a slot. An enqueue with count=DEPTH is a design error; assert it in simulation.
//  - Redirect has priority over pop, enqueue and issue. On a redirect edge:
//    - head=tail=0, count=0, halted=0;
//    - fetch_pc=redirect_pc;
//    - if a request is outstanding and not completing this edge, set drop=1 and keep bus_req/bus_addr held until it completes;
//    - new issue starts on the edge after busy clears.
//  - Misaligned redirect (redirect_pc[1:0]!=0): no bus access.
//    - On the next edge, enqueue {32'd0, redirect_pc, EXC_ALIGN} and set halted.
//    - A redirect arriving while drop=1 replaces fetch_pc again; drop stays 1.
//  - enable=0 blocks new issue only. Outstanding requests complete and pops continue.
// TESTING
//  1 Reset, enable=1, bus_ready on the 2nd cycle of each request -> bus_addr 80000000,80000004,...;
//    count rises to 4 with no pops; bus_req=0 while full.
//  2 Full queue, deq_ready=1 continuously, bus_ready=1 every cycle -> one pop per cycle;
//    deq_pc increments by 4; head/tail wrap past DEPTH-1 with no loss or duplication.
//  3 Redirect to 0x80001000 while a request to 0x80000008 is pending ->
//    its response is dropped; next bus_addr=0x80001000; the first popped deq_pc=0x80001000.
//  4 bus_exc=3'd2 on the fetch of 0x80000004 -> entry deq_exc=2, deq_pc=0x80000004; no further bus_req;
//    a redirect to 0x80000180 resumes fetching.
//  5 Redirect to 0x80000002 -> no bus_req; the next cycle gives deq_valid=1, deq_exc=EXC_ALIGN, deq_pc=0x80000002.
//  6 Assert res mid-request with 3 entries held -> next cycle count=0, bus_req=0, bus_addr=0x80000000.

Source files
------------

// File: rtl/insn_prefetch_queue.sv
// Decoupled instruction prefetcher: issues sequential word fetches on the
// memory bus, with one request outstanding at a time. Fetched words are kept
// in a small circular queue together with their PC and MMU exception code.
// The decode stage pops entries through a valid/ready handshake. Redirects
// flush the queue and restart fetching at a new PC.
module insn_prefetch_queue #(
    parameter int              DEPTH     = 4,
    parameter logic [31:0]     RESET_PC  = 32'h8000_0000,
    parameter int              EXC_W     = 3,
    parameter logic [EXC_W-1:0] EXC_ALIGN = 3'd7
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     enable,
    output logic                     bus_req,
    output logic [31:0]              bus_addr,
    input  logic [31:0]              bus_dataIn,
    input  logic                     bus_ready,
    input  logic [EXC_W-1:0]         bus_exc,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [31:0]              deq_ins,
    output logic [31:0]              deq_pc,
    output logic [EXC_W-1:0]         deq_exc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Occupancy arithmetic can exceed DEPTH by two before the compare.
    localparam int OW = PW + 2;

    logic [31:0]       fetch_pc;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              drop;
    logic              halted;
    logic              align_pend;

    logic [31:0]       mem_ins [DEPTH];
    logic [31:0]       mem_pc  [DEPTH];
    logic [EXC_W-1:0]  mem_exc [DEPTH];

    logic              complete;
    logic              accept;
    logic              enq_bus;
    logic              enq_align;
    logic              enq;
    logic              pop;
    logic              exc_now;
    logic [OW-1:0]     occ;
    logic              room;
    logic              issue;
    logic [31:0]       enq_ins;
    logic [31:0]       enq_pc;
    logic [EXC_W-1:0]  enq_exc;

    // bus_req doubles as the "request outstanding" flag.
    assign complete  = bus_req && (bus_ready || (bus_exc != '0));
    // A completing response is kept unless it belongs to a flushed stream.
    assign accept    = complete && !drop;
    assign enq_bus   = accept && !redirect;
    assign enq_align = align_pend && !redirect;
    assign enq       = enq_bus || enq_align;
    assign pop       = deq_valid && deq_ready && !redirect;
    // An exception completing now must also stop a back-to-back issue.
    assign exc_now   = accept && (bus_exc != '0);

    // Slots already held, plus the one reserved by the in-flight request,
    // plus the one the completing response will occupy, minus the pop.
    assign occ  = OW'(count) + OW'(bus_req) + OW'(accept) - OW'(pop);
    assign room = occ < OW'(DEPTH);

    assign issue = enable && !halted && !redirect && !align_pend && !exc_now
                   && room && (!bus_req || complete);

    // A misaligned redirect enqueues a synthetic fault entry at its own PC.
    assign enq_ins = enq_align ? 32'd0     : bus_dataIn;
    assign enq_pc  = enq_align ? fetch_pc  : bus_addr;
    assign enq_exc = enq_align ? EXC_ALIGN : bus_exc;

    assign deq_valid = (count != '0);
    assign deq_ins   = mem_ins[head];
    assign deq_pc    = mem_pc[head];
    assign deq_exc   = mem_exc[head];

    // Fetch control: bus request, fetch PC, queue pointers and status flags.
    always_ff @(posedge clk) begin
        if (res) begin
            bus_req    <= 1'b0;
            bus_addr   <= RESET_PC;
            fetch_pc   <= RESET_PC;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            drop       <= 1'b0;
            halted     <= 1'b0;
            align_pend <= 1'b0;
        end else if (redirect) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            halted     <= 1'b0;
            fetch_pc   <= redirect_pc;
            align_pend <= (redirect_pc[1:0] != 2'b00);
            // An unfinished request stays on the bus; its data is thrown away.
            if (bus_req && !complete) begin
                drop <= 1'b1;
            end else begin
                drop    <= 1'b0;
                bus_req <= 1'b0;
            end
        end else begin
            if (enq) tail <= tail + PW'(1);
            if (pop) head <= head + PW'(1);
            count <= count + CW'(enq) - CW'(pop);
            if (complete && drop) drop <= 1'b0;
            if (exc_now || enq_align) halted <= 1'b1;
            align_pend <= 1'b0;
            if (issue) begin
                bus_req  <= 1'b1;
                bus_addr <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end else if (complete) begin
                bus_req <= 1'b0;
            end
        end
    end

    // Queue storage: write the tail entry on enqueue.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_ins[i] <= '0;
                mem_pc[i]  <= '0;
                mem_exc[i] <= '0;
            end
        end else if (enq) begin
            mem_ins[tail] <= enq_ins;
            mem_pc[tail]  <= enq_pc;
            mem_exc[tail] <= enq_exc;
        end
    end

    // Slot reservation at issue time makes an enqueue into a full queue impossible.
    assert property (@(posedge clk) disable iff (res) !(enq && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_insn_prefetch_queue.sv
// Bench for insn_prefetch_queue. A memory responder answers fetch requests.
// A reference model follows the fetch stream, which is a sequential PC
// stream that restarts on each redirect or reset. Each request is tagged
// with the stream epoch that was current when it was observed. A completion
// from an older epoch must vanish. The model's in-order queue of entries is
// compared with count and with the head of the queue on every cycle.
module tb_insn_prefetch_queue;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [2:0]  EXC_AL = 3'd7;

    logic        clk = 1'b0;
    logic        res;
    logic        enable;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_dataIn;
    logic        bus_ready;
    logic [2:0]  bus_exc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_ins;
    logic [31:0] deq_pc;
    logic [2:0]  deq_exc;
    logic [2:0]  count;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign bus_dataIn = mem_word(bus_addr);

    insn_prefetch_queue #(
        .DEPTH(4), .RESET_PC(RST_PC), .EXC_W(3), .EXC_ALIGN(EXC_AL)
    ) dut (
        .clk(clk), .res(res), .enable(enable),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_dataIn(bus_dataIn),
        .bus_ready(bus_ready), .bus_exc(bus_exc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_ins(deq_ins), .deq_pc(deq_pc), .deq_exc(deq_exc),
        .count(count)
    );

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [2:0]  exc;
    } ent_t;

    ent_t        mq[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] nf = RST_PC;
    int          epoch = 0;
    int          out_tag = 0;
    logic        out_valid = 1'b0;
    logic [31:0] out_addr = '0;
    int          out_age = 0;
    logic        align_pend_m = 1'b0;
    logic [31:0] align_pc_m = '0;
    int          lat = 1;
    bit          rand_bus = 1'b0;
    logic [31:0] exc_addr = 32'hFFFF_FFFF;
    logic [2:0]  exc_code = 3'd0;
    int          pops = 0;
    int          newreqs = 0;
    logic [31:0] last_new_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive the responder, advance the model, compare.
    task automatic step();
        logic        p_req;
        logic        p_valid;
        logic        comp;
        logic        new_req;
        ent_t        e;
        if (rand_bus) begin
            bus_ready = out_valid && ($urandom_range(0, 2) == 0);
            bus_exc   = (out_valid && $urandom_range(0, 60) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        end else begin
            bus_ready = out_valid && (out_age >= lat);
            bus_exc   = (out_valid && out_age >= lat && out_addr == exc_addr) ? exc_code : 3'd0;
        end
        p_req   = bus_req;
        p_valid = (mq.size() != 0);
        comp    = p_req && (bus_ready || bus_exc != 3'd0);
        if (deq_valid && deq_ready && !redirect && !res) pops++;
        @(posedge clk);
        #1;
        if (res) begin
            mq.delete();
            epoch++;
            align_pend_m = 1'b0;
            nf = RST_PC;
        end else begin
            if (p_valid && deq_ready && !redirect) void'(mq.pop_front());
            if (comp && out_valid && out_tag == epoch && !redirect) begin
                chk("room", 32'(mq.size() < 4), 32'd1);
                e.ins = mem_word(out_addr);
                e.pc  = out_addr;
                e.exc = bus_exc;
                mq.push_back(e);
            end
            if (redirect) begin
                mq.delete();
                epoch++;
                nf = redirect_pc;
                align_pend_m = (redirect_pc[1:0] != 2'b00);
                align_pc_m = redirect_pc;
            end else if (align_pend_m) begin
                e.ins = 32'd0;
                e.pc  = align_pc_m;
                e.exc = EXC_AL;
                mq.push_back(e);
                align_pend_m = 1'b0;
            end
        end
        if (res || comp) out_valid = 1'b0;
        else if (out_valid) out_age++;
        new_req = !res && bus_req && (!p_req || comp);
        if (new_req) begin
            chk("issue_addr", bus_addr, nf);
            nf = nf + 32'd4;
            out_valid = 1'b1;
            out_tag = epoch;
            out_addr = bus_addr;
            out_age = 0;
            newreqs++;
            last_new_addr = bus_addr;
        end else if (out_valid) begin
            chk("hold_addr", bus_addr, out_addr);
        end
        chk("req_state", 32'(bus_req), 32'(out_valid));
        chk("count", 32'(count), 32'(mq.size()));
        chk("deq_valid", 32'(deq_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("deq_ins", deq_ins, mq[0].ins);
            chk("deq_pc", deq_pc, mq[0].pc);
            chk("deq_exc", 32'(deq_exc), 32'(mq[0].exc));
        end
        redirect = 1'b0;
        res = 1'b0;
    endtask

    initial begin
        int n0;
        res = 1'b1; enable = 1'b0; redirect = 1'b0; redirect_pc = '0;
        deq_ready = 1'b0; bus_ready = 1'b0; bus_exc = 3'd0;

        // Reset state
        step();
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_addr", bus_addr, RST_PC);
        chk("rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_deq_ins", deq_ins, 32'd0);
        chk("rst_deq_pc", deq_pc, 32'd0);
        chk("rst_deq_exc", 32'(deq_exc), 32'd0);

        // Fill with two-cycle responses and no pops
        enable = 1'b1; lat = 1; newreqs = 0;
        repeat (20) step();
        chk("t1_count_full", 32'(count), 32'd4);
        chk("t1_req_idle", 32'(bus_req), 32'd0);
        chk("t1_nreq", 32'(newreqs), 32'd4);
        chk("t1_next_pc", nf, 32'h8000_0010);

        // Drain while refilling with single-cycle responses
        deq_ready = 1'b1; lat = 0; pops = 0;
        repeat (10) step();
        chk("t2_pops", 32'(pops), 32'd10);
        deq_ready = 1'b0;

        // Redirect while a request to 0x80000008 is pending
        res = 1'b1; step();
        enable = 1'b1; lat = 3;
        for (int i = 0; i < 40 && !(out_valid && out_addr == 32'h8000_0008 && out_age == 0); i++) step();
        chk("t3_reach", 32'(out_valid && out_addr == 32'h8000_0008), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h8000_1000;
        n0 = newreqs;
        step();
        chk("t3_held", 32'(bus_req), 32'd1);
        for (int i = 0; i < 40 && newreqs == n0; i++) step();
        chk("t3_new_addr", last_new_addr, 32'h8000_1000);
        for (int i = 0; i < 20 && !deq_valid; i++) step();
        chk("t3_first_pc", deq_pc, 32'h8000_1000);
        deq_ready = 1'b1; step(); deq_ready = 1'b0;

        // Exception (with bus_ready also set) on the fetch of 0x80000004
        res = 1'b1; step();
        enable = 1'b1; lat = 1; exc_addr = 32'h8000_0004; exc_code = 3'd2;
        repeat (15) step();
        chk("t4_count", 32'(count), 32'd2);
        chk("t4_req_idle", 32'(bus_req), 32'd0);
        chk("t4_no_more", nf, 32'h8000_0008);
        deq_ready = 1'b1; step(); deq_ready = 1'b0;
        chk("t4_pc", deq_pc, 32'h8000_0004);
        chk("t4_exc", 32'(deq_exc), 32'd2);
        chk("t4_ins", deq_ins, mem_word(32'h8000_0004));
        exc_addr = 32'hFFFF_FFFF;
        redirect = 1'b1; redirect_pc = 32'h8000_0180;
        n0 = newreqs;
        for (int i = 0; i < 10 && newreqs == n0; i++) step();
        chk("t4_resume", last_new_addr, 32'h8000_0180);

        // Misaligned redirect
        res = 1'b1; step();
        enable = 1'b1; redirect = 1'b1; redirect_pc = 32'h8000_0002;
        step();
        chk("t5_no_req", 32'(bus_req), 32'd0);
        step();
        chk("t5_valid", 32'(deq_valid), 32'd1);
        chk("t5_exc", 32'(deq_exc), 32'(EXC_AL));
        chk("t5_pc", deq_pc, 32'h8000_0002);
        repeat (3) step();
        chk("t5_still_no_req", 32'(bus_req), 32'd0);

        // Reset in the middle of a request with three entries held
        res = 1'b1; step();
        enable = 1'b1; lat = 1;
        for (int i = 0; i < 40 && !(count == 3'd3 && bus_req); i++) step();
        chk("t6_reach", 32'(count == 3'd3 && bus_req), 32'd1);
        res = 1'b1; step();
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_req", 32'(bus_req), 32'd0);
        chk("t6_addr", bus_addr, RST_PC);

        // Randomised traffic: responses, pops, enable and redirects
        res = 1'b1; step();
        rand_bus = 1'b1;
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            deq_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 24) == 0) begin
                redirect = 1'b1;
                redirect_pc = {16'h8000, 4'($urandom_range(0, 15)), 10'($urandom_range(0, 1023)), 2'b00};
                if ($urandom_range(0, 5) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
